// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned SERIAL_SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; WIDTH+2 cycles per operation.
// Optional two's-complement overflow port ovf is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 2..32");
    end

    sub_state_e       state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             load, step, finish;
    logic             d_bit, b_bit;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .diff (d_bit),
        .bout (b_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_nxt == IDLE);
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand/result shift registers, borrow and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (step) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
            brw  <= b_bit;
            // Hold on the last bit so the counter never wraps
            if (!finish) cnt <= cnt + CW'(1);
        end
    end

    // Results change only when the last bit completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (finish) begin
            diff <= (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
            bout <= b_bit;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb, b_msb;

    // Operand sign bits are shifted out, so keep copies for the overflow test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (finish) begin
            ovf <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the legal range SHALL be 2..32.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 Port b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 Port ready  output  1  high exactly when state is IDLE.
REQ-008 Port busy  output  1  high exactly when state is SHIFT.
REQ-009 Port done  output  1  high for exactly one cycle, in state DONE.
REQ-010 Port diff  output  WIDTH  result a-b modulo 2^WIDTH; held from DONE until the next accepted start.
REQ-011 Port bout  output  1  final borrow (1 when a<b unsigned); held like diff.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load a and b into shift registers, clear the borrow register and the bit counter, and go to SHIFT.
REQ-014 Each SHIFT cycle SHALL subtract the operand LSBs with the borrow register through one full_subtractor instance.
REQ-015 Each SHIFT cycle SHALL shift the diff bit into the result MSB (right shift), shift both operands right, register the bit borrow and increment the counter.
REQ-016 The block SHALL spend exactly WIDTH cycles in SHIFT, then go to DONE; done SHALL be high in the cycle after edge k+WIDTH, where start was accepted at edge k.
REQ-017 DONE SHALL go unconditionally to IDLE on the next edge; diff, bout and ovf SHALL update only on the SHIFT->DONE edge.
REQ-018 start in SHIFT or DONE SHALL be ignored, with no queuing; a and b changing after acceptance SHALL not affect the result.
REQ-019 start held high continuously SHALL begin a new operation every WIDTH+2 cycles.
REQ-020 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap within one operation.

Reset
REQ-021 While rst_n=0, the block SHALL be in IDLE with ready=1, busy=0, done=0, diff=0, bout=0, ovf=0 and all internal registers zero.
REQ-022 Reset asserted mid-operation SHALL abort it immediately; no done pulse SHALL follow.
REQ-023 After rst_n rises, start SHALL be accepted on the first clock edge.

Configuration
REQ-024 Macro SERIAL_SUB_OVERFLOW_EN, when defined, SHALL add port ovf (output, 1 bit): two's-complement overflow, computed as (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), registered and held like diff.
REQ-025 When SERIAL_SUB_OVERFLOW_EN is undefined, port ovf and its logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the constant SERIAL_SUB_WIDTH_DEFAULT=8.
REQ-027 The bit slice SHALL be the existing full_subtractor module (a, b, bin -> diff, bout), instantiated once; no other sub-modules.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start 1 cycle -> done 9 cycles after acceptance, diff=0x02, bout=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0x00 -> diff=0x00, bout=0; a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-030 Start 0x10-0x01, then pulse start with a=0xAA during SHIFT -> single done, diff=0x0F; the second start is ignored.
REQ-031 Drop rst_n on the 4th SHIFT cycle -> immediate IDLE, outputs zero, no done; the next start 0x09-0x04 -> diff=0x05.
REQ-032 With SERIAL_SUB_OVERFLOW_EN: 0x80-0x01 -> diff=0x7F, ovf=1, bout=0; 0x7F-0xFF -> diff=0x80, ovf=1, bout=1; 0x05-0x03 -> ovf=0.
REQ-033 start held high for 30 cycles -> done pulses spaced exactly 10 cycles apart; exhaustive sweep of all 65536 (a,b) pairs matches a-b modulo 256.
